// File: rtl/lcd_pkg.sv
// Shared state encoding, pin/byte types and HD44780 command constants for the
// 4-bit LCD bus receiver.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_INIT8 = 2'd0,
    ST_HI    = 2'd1,
    ST_LO    = 2'd2
  } lcdState_e;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_HOME_MASK  = 8'hFE;
  localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC;
  localparam logic [7:0] CMD_ENTRY      = 8'h04;
  localparam logic [7:0] CMD_FUNC_MASK  = 8'hE0;
  localparam logic [7:0] CMD_FUNC       = 8'h20;
  localparam int         CMD_DDRAM_BIT  = 7;
  localparam int         CMD_DL_BIT     = 4;

  typedef struct packed {
    logic       rs;
    logic       en;
    logic [3:0] d;
  } lcdPins_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcdByte_t;

  function automatic logic isFuncSet(input logic [7:0] b);
    return (b & CMD_FUNC_MASK) == CMD_FUNC;
  endfunction

  function automatic logic isEntry(input logic [7:0] b);
    return (b & CMD_ENTRY_MASK) == CMD_ENTRY;
  endfunction

  function automatic logic isHome(input logic [7:0] b);
    return (b & CMD_HOME_MASK) == CMD_HOME;
  endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Multi-stage synchroniser on {rs,en,d} with one extra delay stage; flags the
// En falling edge and presents the Rs/data that were valid just before it.
module lcd_sync_edge
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_en,
  input  logic [3:0] lcd_d,
  output logic       fall,
  output logic       rs_d,
  output logic [3:0] d_d
);

  // Entries 0..SYNC_STAGES-1 form the synchroniser, entry SYNC_STAGES is the delay stage.
  lcdPins_t [SYNC_STAGES:0] pinPipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pinPipe <= '0;
    end else begin
      pinPipe[0] <= {lcd_rs, lcd_en, lcd_d};
      for (int i = 1; i <= SYNC_STAGES; i++) pinPipe[i] <= pinPipe[i-1];
    end
  end

  assign fall = pinPipe[SYNC_STAGES].en & ~pinPipe[SYNC_STAGES-1].en;
  assign rs_d = pinPipe[SYNC_STAGES].rs;
  assign d_d  = pinPipe[SYNC_STAGES].d;

endmodule

// File: rtl/lcd_bus_receiver.sv
// HD44780 4-bit bus monitor: assembles nibbles into bytes, tracks 8/4-bit mode
// and mirrors the panel's DDRAM cursor; flags Rs mismatches and nibble timeouts.
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int TO_W        = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_en,
  input  logic [3:0] lcd_d,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       byte_rs,
  output logic [6:0] byte_addr,
  output logic [6:0] cursor,
  output logic       mode_4bit,
  output logic       err,
  output logic [7:0] err_count
);

  logic       fall;
  logic       rsD;
  logic [3:0] dD;

  lcd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSync (
    .clk    (clk),
    .reset  (reset),
    .lcd_rs (lcd_rs),
    .lcd_en (lcd_en),
    .lcd_d  (lcd_d),
    .fall   (fall),
    .rs_d   (rsD),
    .d_d    (dD)
  );

  lcdState_e      state, stateNxt;
  logic [3:0]     hiNib;
  logic           hiRs;
  logic [TO_W-1:0] toCnt;
  logic           incr;

  logic           emit;
  lcdByte_t       emitB;
  logic           rsErr;
  logic           timeout;
  logic           isCmd;
  logic           funcSet;

  // A fall in the same cycle wins over the timeout.
  assign timeout = (TIMEOUT_CYC != 0) && (state == ST_LO) && !fall &&
                   (toCnt == TO_W'(TIMEOUT_CYC - 1));

  assign isCmd   = emit && !emitB.rs;
  assign funcSet = isCmd && isFuncSet(emitB.data);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_INIT8;
    else        state <= stateNxt;
  end

  // Next-state logic
  always_comb begin
    stateNxt = state;
    case (state)
      ST_INIT8: if (funcSet && !emitB.data[CMD_DL_BIT]) stateNxt = ST_HI;
      ST_HI:    if (fall) stateNxt = ST_LO;
      ST_LO: begin
        if (fall)         stateNxt = (funcSet && emitB.data[CMD_DL_BIT]) ? ST_INIT8 : ST_HI;
        else if (timeout) stateNxt = ST_HI;
      end
      default:            stateNxt = ST_INIT8;
    endcase
  end

  // Output decode: which byte (if any) completes this cycle
  always_comb begin
    emit  = 1'b0;
    emitB = '0;
    rsErr = 1'b0;
    case (state)
      ST_INIT8: begin
        if (fall) begin
          emit  = 1'b1;
          emitB = '{rs: rsD, data: {dD, 4'h0}};
        end
      end
      ST_LO: begin
        if (fall) begin
          emit  = 1'b1;
          emitB = '{rs: hiRs, data: {hiNib, dD}};
          rsErr = (rsD != hiRs);
        end
      end
      default: ;
    endcase
  end

  // High-nibble holding register and inter-nibble timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hiNib <= '0;
      hiRs  <= 1'b0;
      toCnt <= '0;
    end else begin
      if (state == ST_HI && fall) begin
        hiNib <= dD;
        hiRs  <= rsD;
      end
      if (state == ST_LO) toCnt <= toCnt + TO_W'(1);
      else                toCnt <= '0;
    end
  end

  // Cursor and entry-mode tracking, mirroring the panel's own DDRAM address counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cursor <= '0;
      incr   <= 1'b1;
    end else if (isCmd) begin
      if (emitB.data[CMD_DDRAM_BIT]) begin
        cursor <= emitB.data[6:0];
      end else if (emitB.data == CMD_CLEAR) begin
        cursor <= '0;
        incr   <= 1'b1;
      end else if (isHome(emitB.data)) begin
        cursor <= '0;
      end else if (isEntry(emitB.data)) begin
        incr   <= emitB.data[1];
      end
    end else if (emit) begin
      cursor <= incr ? cursor + 7'd1 : cursor - 7'd1;
    end
  end

  // Registered byte and error outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_valid <= 1'b0;
      byte_out   <= '0;
      byte_rs    <= 1'b0;
      byte_addr  <= '0;
      mode_4bit  <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      byte_valid <= emit;
      mode_4bit  <= (stateNxt != ST_INIT8);
      err        <= rsErr | timeout;
      if (emit) begin
        byte_out  <= emitB.data;
        byte_rs   <= emitB.rs;
        byte_addr <= emitB.rs ? cursor : 7'd0;
      end
      if ((rsErr | timeout) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Randomised bench for lcd_bus_receiver: a transaction-level panel model
// predicts every decoded byte, error pulse, cursor and mode value.
module tb_lcd_bus_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_en = 1'b0;
  logic [3:0] lcd_d = 4'h0;
  logic       byte_valid;
  logic [7:0] byte_out;
  logic       byte_rs;
  logic [6:0] byte_addr;
  logic [6:0] cursor;
  logic       mode_4bit;
  logic       err;
  logic [7:0] err_count;

  lcd_bus_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYC(100), .TO_W(26)) dut (
    .clk        (clk),
    .reset      (reset),
    .lcd_rs     (lcd_rs),
    .lcd_en     (lcd_en),
    .lcd_d      (lcd_d),
    .byte_valid (byte_valid),
    .byte_out   (byte_out),
    .byte_rs    (byte_rs),
    .byte_addr  (byte_addr),
    .cursor     (cursor),
    .mode_4bit  (mode_4bit),
    .err        (err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChk = 0;
  int nPass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural panel model ----------------
  typedef struct {
    logic       isByte;
    logic [7:0] b;
    logic       rs;
    logic [6:0] addr;
    logic       err;
  } ev_t;

  ev_t        expQ[$];
  bit         m4 = 0;
  bit         haveHi = 0;
  logic [3:0] hiN = 0;
  logic       hiR = 0;
  logic [6:0] mCur = 0;
  bit         mInc = 1;
  int         mErr = 0;
  bit         quiet = 0;
  int         lastFallCyc = 0;

  task automatic modelReset();
    m4 = 0; haveHi = 0; mCur = 0; mInc = 1; mErr = 0;
    expQ.delete();
  endtask

  task automatic bumpErr();
    if (mErr < 255) mErr++;
  endtask

  task automatic modelExec(input logic [7:0] b, input logic brs, input logic e);
    ev_t ev;
    ev.isByte = 1; ev.b = b; ev.rs = brs; ev.err = e;
    ev.addr = brs ? mCur : 7'd0;
    expQ.push_back(ev);
    if (e) bumpErr();
    if (brs) begin
      mCur = mInc ? 7'((int'(mCur) + 1) % 128) : 7'((int'(mCur) + 127) % 128);
    end else if (b >= 8'h80) begin
      mCur = 7'(int'(b) - 128);
    end else if (b == 8'h01) begin
      mCur = 0; mInc = 1;
    end else if (b == 8'h02 || b == 8'h03) begin
      mCur = 0;
    end else if (b >= 8'h04 && b <= 8'h07) begin
      mInc = ((int'(b) / 2) % 2) == 1;
    end else if (b >= 8'h20 && b <= 8'h3F) begin
      if (m4 && b >= 8'h30) m4 = 0;
      else if (!m4 && b < 8'h30) m4 = 1;
    end
  endtask

  task automatic modelNib(input logic rs, input logic [3:0] n);
    if (!m4) modelExec({n, 4'h0}, rs, 1'b0);
    else if (!haveHi) begin haveHi = 1; hiN = n; hiR = rs; end
    else begin haveHi = 0; modelExec({hiN, n}, hiR, rs != hiR); end
  endtask

  task automatic modelTimeout();
    ev_t ev;
    ev.isByte = 0; ev.b = 0; ev.rs = 0; ev.addr = 0; ev.err = 1;
    expQ.push_back(ev);
    haveHi = 0;
    bumpErr();
  endtask

  // ---------------- compare process ----------------
  ev_t cmpEv;
  always @(posedge clk) begin
    #1;
    if (byte_valid || err) begin
      if (expQ.size() == 0) begin
        check("spurious_valid", byte_valid, 0);
        check("spurious_err", err, 0);
      end else begin
        cmpEv = expQ.pop_front();
        check("ev_valid", byte_valid, cmpEv.isByte);
        check("ev_err", err, cmpEv.err);
        if (cmpEv.isByte) begin
          check("ev_byte", byte_out, cmpEv.b);
          check("ev_rs", byte_rs, cmpEv.rs);
          check("ev_addr", byte_addr, cmpEv.addr);
        end
      end
    end
    if (quiet) begin
      check("q_cursor", cursor, mCur);
      check("q_mode", mode_4bit, m4);
      check("q_errcnt", err_count, mErr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic sendNib(input logic rs, input logic [3:0] n);
    @(negedge clk);
    quiet = 0;
    lcd_rs = rs; lcd_d = n; lcd_en = 1;
    repeat ($urandom_range(2, 4)) @(negedge clk);
    lcd_en = 0;
    lastFallCyc = cyc;
    modelNib(rs, n);
    repeat ($urandom_range(5, 12)) @(negedge clk);
    lcd_d = 4'($urandom);
    lcd_rs = 1'($urandom);
    check("drain", expQ.size(), 0);
    quiet = 1;
  endtask

  task automatic sendByte(input logic rs, input logic [7:0] b);
    sendNib(rs, b[7:4]);
    sendNib(rs, b[3:0]);
  endtask

  task automatic expectTimeout();
    bit seen;
    int d;
    seen = 0;
    quiet = 0;
    modelTimeout();
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      if (err) seen = 1;
    end
    d = cyc - lastFallCyc;
    check("timeout_seen", seen, 1);
    check("timeout_latency_ok", (d >= 98 && d <= 108), 1);
    repeat (3) @(negedge clk);
    check("timeout_drain", expQ.size(), 0);
    quiet = 1;
  endtask

  task automatic resetPulse();
    @(negedge clk);
    quiet = 0;
    reset = 0;
    #1;
    check("rst_mode", mode_4bit, 0);
    check("rst_cursor", cursor, 0);
    check("rst_valid", byte_valid, 0);
    check("rst_err", err, 0);
    check("rst_errcnt", err_count, 0);
    check("rst_byte", byte_out, 0);
    modelReset();
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic initSeq();
    sendNib(0, 4'h3); check("init_b1", byte_out, 8'h30);
    sendNib(0, 4'h3); check("init_b2", byte_out, 8'h30);
    sendNib(0, 4'h3); check("init_b3", byte_out, 8'h30);
    check("init_mode8", mode_4bit, 0);
    sendNib(0, 4'h2); check("init_b4", byte_out, 8'h20);
    check("init_mode4", mode_4bit, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hr;
    int r;
    repeat (3) @(negedge clk);
    check("por_valid", byte_valid, 0);
    check("por_cursor", cursor, 0);
    check("por_mode", mode_4bit, 0);
    reset = 1;
    repeat (3) @(negedge clk);

    // directed: init, 'H', addressing, wrap, entry decrement, clear
    initSeq();
    sendNib(1, 4'h4);
    check("h_no_early_valid", byte_valid, 0);
    sendNib(1, 4'h8);
    check("h_byte", byte_out, 8'h48);
    check("h_rs", byte_rs, 1);
    check("h_addr", byte_addr, 7'h00);
    check("h_cursor", cursor, 7'h01);
    sendByte(0, 8'hC0); check("c0_cursor", cursor, 7'h40);
    sendByte(1, 8'h41); check("c0_addr", byte_addr, 7'h40); check("c0_cursor2", cursor, 7'h41);
    sendByte(0, 8'hFF); sendByte(1, 8'h5A);
    check("wrap_addr", byte_addr, 7'h7F); check("wrap_cursor", cursor, 7'h00);
    sendByte(0, 8'h04); sendByte(0, 8'h80); sendByte(1, 8'h20);
    check("dec_addr", byte_addr, 7'h00); check("dec_cursor", cursor, 7'h7F);
    sendByte(0, 8'h01); check("clr_cursor", cursor, 7'h00);
    sendByte(1, 8'h21); check("clr_inc", cursor, 7'h01);

    // errors: Rs mismatch, then timeout followed by a fresh pair
    sendNib(1, 4'h6); sendNib(0, 4'h1);
    check("mis_byte", byte_out, 8'h61); check("mis_rs", byte_rs, 1); check("mis_cnt", err_count, 1);
    sendNib(1, 4'h7);
    expectTimeout();
    check("to_cnt", err_count, 2);
    sendByte(1, 8'h39);
    check("to_fresh", byte_out, 8'h39);

    // reset mid-byte, then return to 8-bit mode via 0x30
    sendNib(1, 4'h5);
    resetPulse();
    initSeq();
    sendByte(0, 8'h30);
    check("back8_mode", mode_4bit, 0);
    sendNib(0, 4'h8);
    check("back8_byte", byte_out, 8'h80);

    // randomised traffic
    for (int k = 0; k < 220; k++) begin
      r = $urandom_range(0, 99);
      if (!m4) sendNib(0, (r < 40) ? 4'h2 : 4'($urandom));
      else if (r < 45) sendByte(1, 8'($urandom));
      else if (r < 80) sendByte(0, 8'($urandom));
      else if (r < 92) begin
        hr = 1'($urandom);
        sendNib(hr, 4'($urandom));
        sendNib(!hr, 4'($urandom));
      end else if (r < 96) begin
        sendNib(1'($urandom), 4'($urandom));
        expectTimeout();
      end else begin
        if (!haveHi) sendNib(1'($urandom), 4'($urandom));
        resetPulse();
      end
    end

    // error counter saturation
    resetPulse();
    initSeq();
    for (int k = 0; k < 260; k++) begin
      sendNib(1, 4'($urandom));
      sendNib(0, 4'($urandom));
    end
    check("sat_errcnt", err_count, 8'hFF);

    quiet = 0;
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
